// File: rtl/modport_handshake_pkg.sv
// Shared constants and types for the modport_handshake valid/ready buffer.
package modport_handshake_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH      = 2;
   localparam int CNT_W      = 16;

   typedef logic [DATA_W_DEF-1:0] payload_t;

endpackage

// File: rtl/modport_handshake_buf.sv
// Two-entry FIFO storage with read/write pointers and occupancy count.
// Exposes the next-cycle occupancy so the top can register src_ready
// without a combinational path from snk_ready.
module modport_handshake_buf
   import modport_handshake_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [1:0]        count,
   output logic [1:0]        count_next
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              do_push;
   logic              do_pop;

   // A pop on an empty buffer or a push on a full one is dropped.
   assign do_pop  = pop  && (count != 2'd0);
   assign do_push = push && (count != 2'(DEPTH));

   assign dout = mem[rd_ptr];

   // Occupancy after this edge; +1 and -1 cancel on a simultaneous push/pop.
   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + 2'd1;
      end else if (do_pop && !do_push) begin
         count_next = count - 2'd1;
      end
   end

   // Storage, pointers and occupancy; reset clears everything so no stale
   // payload can reappear at the head after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_next;
      end
   end

endmodule

// File: rtl/modport_handshake.sv
// Valid/ready skid buffer (2 entries) with a sticky producer protocol check.
// Optional statistics counters are enabled by defining MODPORT_HANDSHAKE_STATS_EN.
module modport_handshake
   import modport_handshake_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic [DATA_W-1:0] snk_data,
   output logic              snk_valid,
   input  logic              snk_ready,
   output logic              proto_err
`ifdef MODPORT_HANDSHAKE_STATS_EN
   ,
   output logic [CNT_W-1:0]  in_cnt,
   output logic [CNT_W-1:0]  out_cnt
`endif
);

   logic              push;
   logic              pop;
   logic [1:0]        count;
   logic [1:0]        count_next;
   logic              prev_valid;
   logic              prev_ready;
   logic [DATA_W-1:0] prev_data;

   assign push      = src_valid && src_ready;
   assign snk_valid = (count != 2'd0);
   assign pop       = snk_valid && snk_ready;

   modport_handshake_buf #(
      .DATA_W(DATA_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .din       (src_data),
      .dout      (snk_data),
      .count     (count),
      .count_next(count_next)
   );

   // src_ready is registered from the next occupancy, so it stays 0 in reset
   // and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ready <= 1'b0;
      end else begin
         src_ready <= (count_next < 2'(DEPTH));
      end
   end

   // Remember last cycle's producer signals; a stalled offer that is then
   // withdrawn or altered sets proto_err until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
         prev_ready <= 1'b0;
         prev_data  <= '0;
         proto_err  <= 1'b0;
      end else begin
         prev_valid <= src_valid;
         prev_ready <= src_ready;
         prev_data  <= src_data;
         if (prev_valid && !prev_ready && (!src_valid || (src_data != prev_data))) begin
            proto_err <= 1'b1;
         end
      end
   end

`ifdef MODPORT_HANDSHAKE_STATS_EN
   // Transfer counters on each side, wrapping naturally at 2**CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         if (push) begin
            in_cnt <= in_cnt + 1'b1;
         end
         if (pop) begin
            out_cnt <= out_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_modport_handshake.sv
// Directed self-checking bench for modport_handshake.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_modport_handshake;

   logic       clk;
   logic       rst_n;
   logic [7:0] src_data;
   logic       src_valid;
   logic       src_ready;
   logic [7:0] snk_data;
   logic       snk_valid;
   logic       snk_ready;
   logic       proto_err;
`ifdef MODPORT_HANDSHAKE_STATS_EN
   logic [15:0] in_cnt;
   logic [15:0] out_cnt;
`endif

   int errors = 0;
   int checks = 0;

   modport_handshake #(
      .DATA_W(8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_data (src_data),
      .src_valid(src_valid),
      .src_ready(src_ready),
      .snk_data (snk_data),
      .snk_valid(snk_valid),
      .snk_ready(snk_ready),
      .proto_err(proto_err)
`ifdef MODPORT_HANDSHAKE_STATS_EN
      ,
      .in_cnt   (in_cnt),
      .out_cnt  (out_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      src_data  = 8'h00;
      src_valid = 1'b0;
      snk_ready = 1'b0;

      // Reset release
      repeat (3) step();
      chk("rst_src_ready", 32'(src_ready), 0);
      chk("rst_snk_valid", 32'(snk_valid), 0);
      chk("rst_snk_data",  32'(snk_data),  0);
      chk("rst_proto_err", 32'(proto_err), 0);
      rst_n = 1'b1;
      step();
      chk("rel_src_ready", 32'(src_ready), 1);
      chk("rel_snk_valid", 32'(snk_valid), 0);

      // Single transfer
      src_data  = 8'hA5;
      src_valid = 1'b1;
      snk_ready = 1'b1;
      step();
      src_valid = 1'b0;
      chk("single_valid", 32'(snk_valid), 1);
      chk("single_data",  32'(snk_data),  32'hA5);
      step();
      chk("single_gone",  32'(snk_valid), 0);

      // Back-pressure
      snk_ready = 1'b0;
      src_valid = 1'b1;
      src_data  = 8'h11;
      step();
      chk("bp_rdy1",  32'(src_ready), 1);
      chk("bp_data1", 32'(snk_data),  32'h11);
      src_data = 8'h22;
      step();
      src_valid = 1'b0;
      chk("bp_full_rdy", 32'(src_ready), 0);
      chk("bp_head",     32'(snk_data),  32'h11);
      step();
      chk("bp_hold_valid", 32'(snk_valid), 1);
      chk("bp_hold_data",  32'(snk_data),  32'h11);
      snk_ready = 1'b1;
      step();
      chk("bp_out2",   32'(snk_data),  32'h22);
      chk("bp_valid2", 32'(snk_valid), 1);
      chk("bp_rdy_back", 32'(src_ready), 1);
      step();
      chk("bp_empty", 32'(snk_valid), 0);

      // Reset mid-operation with two entries buffered
      snk_ready = 1'b0;
      src_valid = 1'b1;
      src_data  = 8'h55;
      step();
      src_data = 8'h66;
      step();
      src_valid = 1'b0;
      chk("mid_full_rdy", 32'(src_ready), 0);
      chk("mid_full_vld", 32'(snk_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(snk_valid), 0);
      chk("mid_rst_data",  32'(snk_data),  0);
      chk("mid_rst_rdy",   32'(src_ready), 0);
`ifdef MODPORT_HANDSHAKE_STATS_EN
      chk("mid_rst_in_cnt", 32'(in_cnt), 0);
      chk("mid_rst_out_cnt", 32'(out_cnt), 0);
`endif
      step();
      step();
      rst_n = 1'b1;
      snk_ready = 1'b1;
      step();
      chk("mid_rel_valid", 32'(snk_valid), 0);
      chk("mid_rel_rdy",   32'(src_ready), 1);
      step();
      chk("mid_no_stale",  32'(snk_valid), 0);

      // Streaming 0x00..0xFF with both sides always ready
      src_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         src_data = 8'(i);
         step();
         chk("stream_data",  32'(snk_data),  32'(i));
         chk("stream_rdy",   32'(src_ready), 1);
         chk("stream_valid", 32'(snk_valid), 1);
      end
      src_valid = 1'b0;
      step();
      chk("stream_drain", 32'(snk_valid), 0);
      chk("stream_err",   32'(proto_err), 0);
`ifdef MODPORT_HANDSHAKE_STATS_EN
      chk("stream_in_cnt",  32'(in_cnt),  256);
      chk("stream_out_cnt", 32'(out_cnt), 256);
`endif

      // Protocol violation: stalled offer changes its data
      snk_ready = 1'b0;
      src_valid = 1'b1;
      src_data  = 8'hA0;
      step();
      src_data = 8'hA1;
      step();
      chk("pv_stalled", 32'(src_ready), 0);
      src_data = 8'h33;
      step();
      chk("pv_first_33", 32'(proto_err), 0);
      step();
      chk("pv_hold_33",  32'(proto_err), 0);
      src_data = 8'h44;
      step();
      chk("pv_set", 32'(proto_err), 1);
      src_valid = 1'b0;
      snk_ready = 1'b1;
      repeat (3) step();
      chk("pv_sticky", 32'(proto_err), 1);
      rst_n = 1'b0;
      #1;
      chk("pv_cleared", 32'(proto_err), 0);
      step();
      rst_n = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
